// File: rtl/reg_packer.sv
// Packs 24-bit pixel words little-endian into a 128-bit staging buffer and
// presents the oldest 64 packed bits as an output word.
module reg_packer (
    input  logic        clk,
    input  logic        reset,
    input  logic [23:0] data_in,
    input  logic        push,
    input  logic        flush,
    input  logic        pop,
    output logic [63:0] data_o,
    output logic        valid,
    output logic        full,
    output logic [4:0]  count
);

    logic [127:0] pack_q, pack_d, base_pack;
    logic [7:0]   fill_q, fill_d, base_fill;
    logic         push_ok, pop_ok, flush_ok;

    assign data_o = pack_q[63:0];
    assign valid  = (fill_q >= 8'd64);
    assign full   = (fill_q > 8'd104);
    assign count  = fill_q[7:3];

    always_comb begin
        pop_ok   = pop && valid;
        push_ok  = push && !full;
        // Flush only pads a partial word, and only on an otherwise idle cycle.
        flush_ok = flush && !push && !pop && (fill_q != 8'd0) && (fill_q < 8'd64);

        base_pack = pop_ok ? {64'd0, pack_q[127:64]} : pack_q;
        base_fill = pop_ok ? (fill_q - 8'd64) : fill_q;

        pack_d = base_pack;
        fill_d = base_fill;
        if (push_ok) begin
            // Bits at or above fill are zero, so OR-ing in the new word is safe.
            pack_d = base_pack | ({104'd0, data_in} << base_fill);
            fill_d = base_fill + 8'd24;
        end else if (flush_ok) begin
            fill_d = 8'd64;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pack_q <= 128'd0;
            fill_q <= 8'd0;
        end else begin
            pack_q <= pack_d;
            fill_q <= fill_d;
        end
    end

endmodule

// File: tb/tb_reg_packer.sv
// Self-checking bench for reg_packer: directed scenarios plus a scoreboard
// of expected output words built from a reference bit concatenation.
module tb_reg_packer;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [23:0] data_in = 24'd0;
    logic        push = 1'b0;
    logic        flush = 1'b0;
    logic        pop = 1'b0;
    logic [63:0] data_o;
    logic        valid;
    logic        full;
    logic [4:0]  count;

    int n_checks = 0;
    int n_pass   = 0;

    logic [63:0]  exp_q[$];
    logic [255:0] ref_bits;
    int           ref_len;

    reg_packer dut (
        .clk    (clk),
        .reset  (reset),
        .data_in(data_in),
        .push   (push),
        .flush  (flush),
        .pop    (pop),
        .data_o (data_o),
        .valid  (valid),
        .full   (full),
        .count  (count)
    );

    always #5 clk = ~clk;

    // Inputs change 1ns after a rising edge; outputs are sampled there too.
    task automatic step(input logic p, input logic q, input logic f, input logic [23:0] d);
        push = p; pop = q; flush = f; data_in = d;
        @(posedge clk); #1;
        push = 1'b0; pop = 1'b0; flush = 1'b0; data_in = 24'd0;
    endtask

    // Reference stream: append 24 bits; every completed 64-bit word is queued.
    task automatic ref_append(input logic [23:0] d, input int nbits);
        logic [255:0] ext;
        ext = {232'd0, d};
        ref_bits = ref_bits | (ext << ref_len);
        ref_len += nbits;
        if (ref_len >= 64) begin
            exp_q.push_back(ref_bits[63:0]);
            ref_bits = ref_bits >> 64;
            ref_len -= 64;
        end
    endtask

    task automatic ref_clear();
        ref_bits = '0;
        ref_len  = 0;
        exp_q.delete();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step(1'b0, 1'b0, 1'b0, 24'd0);
        reset = 1'b0;
        ref_clear();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step(1'b1, 1'b1, 1'b1, 24'hFFFFFF);
        reset = 1'b0;
        ref_clear();
        n_checks++; if (data_o !== 64'd0) $display("FAIL reset_data: got %h want 0", data_o); else n_pass++;
        n_checks++; if (valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", valid); else n_pass++;
        n_checks++; if (full !== 1'b0) $display("FAIL reset_full: got %b want 0", full); else n_pass++;
        n_checks++; if (count !== 5'd0) $display("FAIL reset_count: got %0d want 0", count); else n_pass++;
    endtask

    task automatic test_basic();
        logic [63:0] exp_w;
        do_reset();
        step(1'b1, 1'b0, 1'b0, 24'hAAAAAA); ref_append(24'hAAAAAA, 24);
        step(1'b1, 1'b0, 1'b0, 24'hBBBBBB); ref_append(24'hBBBBBB, 24);
        step(1'b1, 1'b0, 1'b0, 24'hCCCCCC); ref_append(24'hCCCCCC, 24);
        n_checks++; if (valid !== 1'b1) $display("FAIL basic_valid: got %b want 1", valid); else n_pass++;
        n_checks++; if (count !== 5'd9) $display("FAIL basic_count: got %0d want 9", count); else n_pass++;
        exp_w = (exp_q.size() > 0) ? exp_q.pop_front() : 64'hX;
        n_checks++; if (data_o !== exp_w || exp_w !== 64'hCCCCBBBBBBAAAAAA)
            $display("FAIL basic_word: got %h want %h", data_o, 64'hCCCCBBBBBBAAAAAA); else n_pass++;
        step(1'b0, 1'b1, 1'b0, 24'd0);
        n_checks++; if (valid !== 1'b0) $display("FAIL basic_pop_valid: got %b want 0", valid); else n_pass++;
        n_checks++; if (count !== 5'd1) $display("FAIL basic_pop_count: got %0d want 1", count); else n_pass++;
        n_checks++; if (data_o !== 64'h00000000000000CC)
            $display("FAIL basic_pop_data: got %h want 00000000000000cc", data_o); else n_pass++;
        // Pop with nothing valid must leave the partial byte alone.
        step(1'b0, 1'b1, 1'b0, 24'd0);
        n_checks++; if (count !== 5'd1 || data_o !== 64'h00000000000000CC)
            $display("FAIL basic_reject_pop: got count %0d data %h want 1 cc", count, data_o); else n_pass++;
    endtask

    task automatic test_full();
        do_reset();
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0, 24'h100000 + 24'(i));
        n_checks++; if (count !== 5'd15) $display("FAIL full_count: got %0d want 15", count); else n_pass++;
        n_checks++; if (full !== 1'b1) $display("FAIL full_flag: got %b want 1", full); else n_pass++;
        step(1'b1, 1'b0, 1'b0, 24'hDEADBE);
        n_checks++; if (count !== 5'd15) $display("FAIL full_reject_count: got %0d want 15", count); else n_pass++;
        n_checks++; if (data_o !== 64'h0002100001100000)
            $display("FAIL full_word: got %h want 0002100001100000", data_o); else n_pass++;
        step(1'b0, 1'b1, 1'b0, 24'd0);
        n_checks++; if (count !== 5'd7) $display("FAIL full_pop_count: got %0d want 7", count); else n_pass++;
        n_checks++; if (full !== 1'b0) $display("FAIL full_pop_flag: got %b want 0", full); else n_pass++;
        // Remaining 56 bits: top of word2, all of words 3 and 4; rejected push leaves no trace.
        n_checks++; if (data_o !== 64'h0010000410000310)
            $display("FAIL full_remainder: got %h want 0010000410000310", data_o); else n_pass++;
    endtask

    task automatic test_back_to_back();
        do_reset();
        step(1'b1, 1'b0, 1'b0, 24'h111111);
        step(1'b1, 1'b0, 1'b0, 24'h222222);
        step(1'b1, 1'b0, 1'b0, 24'h333333);
        step(1'b1, 1'b1, 1'b0, 24'hABCDEF);
        n_checks++; if (count !== 5'd4) $display("FAIL b2b_count: got %0d want 4", count); else n_pass++;
        n_checks++; if (data_o[31:8] !== 24'hABCDEF)
            $display("FAIL b2b_pushed: got %h want abcdef", data_o[31:8]); else n_pass++;
        n_checks++; if (data_o !== 64'h00000000ABCDEF33)
            $display("FAIL b2b_word: got %h want 00000000abcdef33", data_o); else n_pass++;
    endtask

    task automatic test_stream();
        int          n_words;
        logic [63:0] exp_w;
        do_reset();
        n_words = 0;
        for (int i = 1; i <= 8; i++) begin
            if (valid) begin
                exp_w = (exp_q.size() > 0) ? exp_q.pop_front() : 64'hX;
                n_checks++; if (data_o !== exp_w)
                    $display("FAIL stream_word%0d: got %h want %h", n_words, data_o, exp_w); else n_pass++;
                n_words++;
            end
            ref_append(24'(i), 24);
            step(1'b1, valid, 1'b0, 24'(i));
        end
        for (int k = 0; k < 8 && valid; k++) begin
            exp_w = (exp_q.size() > 0) ? exp_q.pop_front() : 64'hX;
            n_checks++; if (data_o !== exp_w)
                $display("FAIL stream_word%0d: got %h want %h", n_words, data_o, exp_w); else n_pass++;
            n_words++;
            step(1'b0, 1'b1, 1'b0, 24'd0);
        end
        n_checks++; if (n_words !== 3) $display("FAIL stream_nwords: got %0d want 3", n_words); else n_pass++;
        n_checks++; if (count !== 5'd0) $display("FAIL stream_count: got %0d want 0", count); else n_pass++;
        n_checks++; if (exp_q.size() !== 0)
            $display("FAIL stream_leftover: got %0d want 0 queued", exp_q.size()); else n_pass++;
    endtask

    task automatic test_flush();
        do_reset();
        step(1'b0, 1'b0, 1'b1, 24'd0);
        n_checks++; if (count !== 5'd0 || valid !== 1'b0)
            $display("FAIL flush_empty: got count %0d valid %b want 0 0", count, valid); else n_pass++;
        step(1'b1, 1'b0, 1'b0, 24'h123456);
        step(1'b0, 1'b0, 1'b1, 24'd0);
        n_checks++; if (valid !== 1'b1) $display("FAIL flush_valid: got %b want 1", valid); else n_pass++;
        n_checks++; if (count !== 5'd8) $display("FAIL flush_count: got %0d want 8", count); else n_pass++;
        n_checks++; if (data_o !== 64'h0000000000123456)
            $display("FAIL flush_data: got %h want 0000000000123456", data_o); else n_pass++;
        // A flush with push active is ignored; the push itself proceeds.
        step(1'b0, 1'b1, 1'b0, 24'd0);
        step(1'b1, 1'b0, 1'b1, 24'h654321);
        n_checks++; if (count !== 5'd3 || valid !== 1'b0)
            $display("FAIL flush_with_push: got count %0d valid %b want 3 0", count, valid); else n_pass++;
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0, 24'h5A5A5A);
        n_checks++; if (count !== 5'd12 || valid !== 1'b1)
            $display("FAIL rmid_pre: got count %0d valid %b want 12 1", count, valid); else n_pass++;
        reset = 1'b1;
        step(1'b1, 1'b1, 1'b1, 24'h777777);
        reset = 1'b0;
        n_checks++; if (count !== 5'd0) $display("FAIL rmid_count: got %0d want 0", count); else n_pass++;
        n_checks++; if (valid !== 1'b0) $display("FAIL rmid_valid: got %b want 0", valid); else n_pass++;
        n_checks++; if (data_o !== 64'd0) $display("FAIL rmid_data: got %h want 0", data_o); else n_pass++;
        step(1'b1, 1'b0, 1'b0, 24'hABCDEF);
        n_checks++; if (data_o !== 64'h0000000000ABCDEF || count !== 5'd3)
            $display("FAIL rmid_first_push: got %h count %0d want abcdef 3", data_o, count); else n_pass++;
    endtask

    initial begin
        ref_clear();
        @(posedge clk); #1;
        test_reset();
        test_basic();
        test_full();
        test_back_to_back();
        test_stream();
        test_flush();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
